concat_read_fifo_param: RTL and testbench

CONCAT_READ_FIFO_PARAM -- requirements
Module: concat_read_fifo_param

---
 rtl/concat_read_fifo_param.sv | 97 +++++++++
 tb/tb_concat_read_fifo_param.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/concat_read_fifo_param.sv
// rtl/concat_read_fifo_param.sv - parameterised synchronous FIFO with programmable front/back ready thresholds
module concat_read_fifo_param #(
  parameter int WIDTH     = 128,
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     din,
  input  logic                 wr_en,
  input  logic                 rd_en,
  output logic [WIDTH-1:0]     dout,
  output logic                 dout_valid,
  input  logic [ADDR_BITS:0]   M_count,
  output logic                 M_Ready,
  input  logic [ADDR_BITS:0]   S_count,
  output logic                 S_Ready,
  output logic [ADDR_BITS:0]   data_count,
  output logic                 full,
  output logic                 empty,
  output logic                 overflow,
  output logic                 underflow,
  input  logic                 err_clr
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] DEPTH_W = (ADDR_BITS + 1)'(1) << ADDR_BITS;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [ADDR_BITS-1:0] wptr;
  logic [ADDR_BITS-1:0] rptr;
  logic                 wr_acc;
  logic                 rd_acc;

  assign full   = (data_count == DEPTH_W);
  assign empty  = (data_count == '0);
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  // RAM has no reset so it maps onto block memory.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= rd_acc;
      if (rd_acc) begin
        dout <= mem[rptr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      data_count <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) rptr <= rptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   data_count <= data_count + 1'b1;
        2'b01:   data_count <= data_count - 1'b1;
        default: data_count <= data_count;
      endcase
    end
  end

  // Flags sample the pre-update occupancy, giving a deliberate one-cycle lag.
  always_ff @(posedge clk) begin
    if (rst) begin
      M_Ready <= 1'b0;
      S_Ready <= 1'b1;
    end else begin
      M_Ready <= (data_count >= M_count);
      S_Ready <= (data_count < S_count);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full)       overflow <= 1'b1;
      else if (err_clr)        overflow <= 1'b0;
      if (rd_en && empty)      underflow <= 1'b1;
      else if (err_clr)        underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_concat_read_fifo_param.sv
// tb/tb_concat_read_fifo_param.sv - directed self-checking bench for concat_read_fifo_param
module tb_concat_read_fifo_param;

  localparam int WIDTH = 32;
  localparam int AB    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] din;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic [AB:0]      M_count;
  logic             M_Ready;
  logic [AB:0]      S_count;
  logic             S_Ready;
  logic [AB:0]      data_count;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             underflow;
  logic             err_clr;

  int checks = 0;
  int errors = 0;

  concat_read_fifo_param #(.WIDTH(WIDTH), .ADDR_BITS(AB)) dut (
    .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .dout(dout), .dout_valid(dout_valid), .M_count(M_count), .M_Ready(M_Ready),
    .S_count(S_count), .S_Ready(S_Ready), .data_count(data_count),
    .full(full), .empty(empty), .overflow(overflow), .underflow(underflow),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; din = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    M_count = 5'd4; S_count = 5'd16;
    do_reset();
    checks++; if (data_count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", data_count); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_empty_full got %b%b want 10", empty, full); end
    checks++; if (dout !== 32'd0 || dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dout got %h/%b want 0/0", dout, dout_valid); end
    checks++; if (M_Ready !== 1'b0 || S_Ready !== 1'b1) begin errors++; $display("FAIL reset_ready got M%b S%b want M0 S1", M_Ready, S_Ready); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL reset_err got %b%b want 00", overflow, underflow); end
  endtask

  task automatic test_mready();
    M_count = 5'd4; S_count = 5'd16;
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      din = i; wr_en = 1'b1; tick();
    end
    wr_en = 1'b0;
    checks++; if (data_count !== 5'd4) begin errors++; $display("FAIL mready_count got %0d want 4", data_count); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL mready_empty got %b want 0", empty); end
    checks++; if (M_Ready !== 1'b0) begin errors++; $display("FAIL mready_lag got %b want 0", M_Ready); end
    tick();
    checks++; if (M_Ready !== 1'b1) begin errors++; $display("FAIL mready_rise got %b want 1", M_Ready); end
  endtask

  task automatic test_full_overflow();
    M_count = 5'd4; S_count = 5'd16;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      din = 100 + i; wr_en = 1'b1; tick();
    end
    checks++; if (full !== 1'b1 || data_count !== 5'd16) begin errors++; $display("FAIL full got full=%b count=%0d want 1/16", full, data_count); end
    din = 32'hDEAD; tick();
    checks++; if (overflow !== 1'b1 || data_count !== 5'd16) begin errors++; $display("FAIL overflow got ovf=%b count=%0d want 1/16", overflow, data_count); end
    wr_en = 1'b0; err_clr = 1'b1; tick(); err_clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL err_clr got %b want 0", overflow); end
    wr_en = 1'b1; rd_en = 1'b1; tick();
    wr_en = 1'b0; rd_en = 1'b0;
    checks++; if (data_count !== 5'd15 || overflow !== 1'b1) begin errors++; $display("FAIL full_wr_rd got count=%0d ovf=%b want 15/1", data_count, overflow); end
    checks++; if (dout !== 32'd100 || dout_valid !== 1'b1) begin errors++; $display("FAIL full_wr_rd_dout got %0d/%b want 100/1", dout, dout_valid); end
    din = 32'd200; wr_en = 1'b1; err_clr = 1'b1; tick();
    wr_en = 1'b0; tick();
    checks++; if (overflow !== 1'b0 || full !== 1'b1) begin errors++; $display("FAIL refill got ovf=%b full=%b want 0/1", overflow, full); end
    wr_en = 1'b1; err_clr = 1'b1; tick();
    wr_en = 1'b0; err_clr = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL set_wins got %b want 1", overflow); end
  endtask

  task automatic test_read();
    logic [WIDTH-1:0] vals [3];
    vals[0] = 32'h0000_000A; vals[1] = 32'h0000_000B; vals[2] = 32'h0000_000C;
    M_count = 5'd4; S_count = 5'd16;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      din = vals[i]; wr_en = 1'b1; tick();
    end
    wr_en = 1'b0; rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (dout !== vals[i] || dout_valid !== 1'b1) begin errors++; $display("FAIL read_%0d got %h/%b want %h/1", i, dout, dout_valid, vals[i]); end
    end
    tick(); rd_en = 1'b0;
    checks++; if (underflow !== 1'b1 || dout_valid !== 1'b0) begin errors++; $display("FAIL underflow got udf=%b vld=%b want 1/0", underflow, dout_valid); end
    checks++; if (dout !== 32'h0000_000C) begin errors++; $display("FAIL dout_hold got %h want 0000000c", dout); end
  endtask

  task automatic test_empty_wr_rd();
    do_reset();
    din = 32'h1234_5678; wr_en = 1'b1; rd_en = 1'b1; tick();
    wr_en = 1'b0; rd_en = 1'b0;
    checks++; if (data_count !== 5'd1 || underflow !== 1'b1) begin errors++; $display("FAIL empty_wr_rd got count=%0d udf=%b want 1/1", data_count, underflow); end
    checks++; if (dout_valid !== 1'b0 || dout !== 32'd0) begin errors++; $display("FAIL no_read_through got %h/%b want 0/0", dout, dout_valid); end
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    checks++; if (dout !== 32'h1234_5678 || dout_valid !== 1'b1) begin errors++; $display("FAIL empty_wr_rd_data got %h/%b want 12345678/1", dout, dout_valid); end
  endtask

  task automatic test_wrap();
    int bad = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      din = 1000 + i; wr_en = 1'b1; tick();
    end
    rd_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      din = 1000 + 5 + i; tick();
      checks++;
      if (dout !== 32'(1000 + i) || dout_valid !== 1'b1 || data_count !== 5'd5) begin
        errors++; bad++;
        if (bad < 5) $display("FAIL wrap_%0d got dout=%0d cnt=%0d want %0d/5", i, dout, data_count, 1000 + i);
      end
    end
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_sready();
    M_count = 5'd4; S_count = 5'd8;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      din = i; wr_en = 1'b1; tick();
    end
    wr_en = 1'b0; tick();
    checks++; if (S_Ready !== 1'b1) begin errors++; $display("FAIL sready_7 got %b want 1", S_Ready); end
    wr_en = 1'b1; tick(); wr_en = 1'b0;
    checks++; if (S_Ready !== 1'b1) begin errors++; $display("FAIL sready_lag got %b want 1", S_Ready); end
    tick();
    checks++; if (S_Ready !== 1'b0) begin errors++; $display("FAIL sready_8 got %b want 0", S_Ready); end
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    checks++; if (S_Ready !== 1'b0) begin errors++; $display("FAIL sready_rd_lag got %b want 0", S_Ready); end
    tick();
    checks++; if (S_Ready !== 1'b1) begin errors++; $display("FAIL sready_rd got %b want 1", S_Ready); end
  endtask

  task automatic test_thresholds();
    M_count = 5'd0; S_count = 5'd0;
    do_reset();
    tick();
    checks++; if (M_Ready !== 1'b1 || S_Ready !== 1'b0) begin errors++; $display("FAIL zero_thr got M%b S%b want M1 S0", M_Ready, S_Ready); end
    S_count = 5'd17;
    for (int i = 0; i < 16; i++) begin
      din = i; wr_en = 1'b1; tick();
    end
    wr_en = 1'b0; tick();
    checks++; if (S_Ready !== 1'b1 || full !== 1'b1) begin errors++; $display("FAIL big_thr got S%b full=%b want 1/1", S_Ready, full); end
    M_count = 5'd17; tick();
    checks++; if (M_Ready !== 1'b0) begin errors++; $display("FAIL m_thr_change got %b want 0", M_Ready); end
  endtask

  task automatic test_mid_reset();
    M_count = 5'd4; S_count = 5'd14;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      din = i; wr_en = 1'b1; tick();
    end
    rd_en = 1'b1; tick(); tick();
    rst = 1'b1; tick();
    checks++; if (data_count !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL midrst_count got %0d/%b want 0/1", data_count, empty); end
    checks++; if (M_Ready !== 1'b0 || S_Ready !== 1'b1 || dout_valid !== 1'b0) begin errors++; $display("FAIL midrst_flags got M%b S%b V%b want 0 1 0", M_Ready, S_Ready, dout_valid); end
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; tick();
    checks++; if (data_count !== 5'd0 || underflow !== 1'b0) begin errors++; $display("FAIL midrst_after got cnt=%0d udf=%b want 0/0", data_count, underflow); end
  endtask

  initial begin
    rst = 1'b1; din = '0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
    M_count = 5'd4; S_count = 5'd16;
    test_reset();
    test_mready();
    test_full_overflow();
    test_read();
    test_empty_wr_rd();
    test_wrap();
    test_sready();
    test_thresholds();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
